// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the Wishbone master arbiter: FSM encoding, priority
// mode names and a constant-friendly clog2.
package wb_master_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam string MODE_FIXED = "FIXED";
    localparam string MODE_RR    = "RR";

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_master_arbiter_if.sv
// Bundle of the core-side and system-side Wishbone signals around the arbiter.
interface wb_master_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [NUM_MASTERS-1:0]            m_cyc_i;
    logic [NUM_MASTERS-1:0]            m_stb_i;
    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
    logic [NUM_MASTERS-1:0]            m_ack_o;
    logic [NUM_MASTERS-1:0]            m_err_o;
    logic [DATA_WIDTH-1:0]             m_dat_o;

    logic                              s_cyc_o;
    logic                              s_stb_o;
    logic                              s_we_o;
    logic [SEL_WIDTH-1:0]              s_sel_o;
    logic [ADDR_WIDTH-1:0]             s_addr_o;
    logic [DATA_WIDTH-1:0]             s_dat_o;
    logic                              s_ack_i;
    logic                              s_err_i;
    logic [DATA_WIDTH-1:0]             s_dat_i;

    // Wishbone classic handshake: a beat is requested while cyc & stb are high
    // and completes in the cycle ack or err is high; holding cyc across beats
    // keeps the bus locked to that master.
    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_addr_i, m_dat_i,
        output m_ack_o, m_err_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_dat_o,
        input  s_ack_i, s_err_i, s_dat_i
    );

    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_addr_i, m_dat_i,
        input  m_ack_o, m_err_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_dat_o,
        output s_ack_i, s_err_i, s_dat_i
    );

endinterface

// File: rtl/wb_arb_picker.sv
// Combinational request selector: lowest index wins, or in round-robin mode
// the first requester at or after the pointer, wrapping cyclically.
module wb_arb_picker #(
    parameter int NUM_MASTERS = 2,
    parameter bit ROUND_ROBIN = 1'b0,
    parameter int PTR_WIDTH   = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_WIDTH-1:0]   ptr,
    output logic [NUM_MASTERS-1:0] grant
);

    int                   sum;
    logic [PTR_WIDTH-1:0] idx;
    logic                 found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sum = ROUND_ROBIN ? int'(ptr) + i : i;
            if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
            idx = PTR_WIDTH'(sum);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// N-to-1 Wishbone classic arbiter with bus lock on cyc, fixed or round-robin
// priority and a watchdog that terminates unanswered strobes with err.
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int    NUM_MASTERS    = 2,
    parameter int    ADDR_WIDTH     = 32,
    parameter int    DATA_WIDTH     = 32,
    parameter string PRIORITY_MODE  = "FIXED",
    parameter int    TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    wb_master_arbiter_if.master    bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output state_t                 state_o
);

    localparam int SEL_WIDTH   = DATA_WIDTH / 8;
    localparam int PTR_WIDTH   = (NUM_MASTERS > 1) ? clog2(NUM_MASTERS) : 1;
    localparam int WD_WIDTH    = (TIMEOUT_CYCLES > 0) ? clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit ROUND_ROBIN = (PRIORITY_MODE == MODE_RR);

    state_t                 state;
    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] pick;
    logic [PTR_WIDTH-1:0]   rr_ptr;
    logic [PTR_WIDTH-1:0]   win_idx;
    logic [PTR_WIDTH-1:0]   gnt_idx;
    logic [WD_WIDTH-1:0]    wd_cnt;
    logic                   busy;
    logic                   cyc_g;
    logic                   stb_g;
    logic                   timeout;

    wb_arb_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .ROUND_ROBIN (ROUND_ROBIN),
        .PTR_WIDTH   (PTR_WIDTH)
    ) u_picker (
        .req   (bus.m_cyc_i),
        .ptr   (rr_ptr),
        .grant (pick)
    );

    always_comb begin
        win_idx = '0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick[i])  win_idx = PTR_WIDTH'(i);
            if (grant[i]) gnt_idx = PTR_WIDTH'(i);
        end
    end

    assign busy  = (state == BUSY);
    assign cyc_g = busy & bus.m_cyc_i[gnt_idx];
    assign stb_g = busy & bus.m_stb_i[gnt_idx];

    // Slave ack/err in the same cycle as the limit takes precedence over the timeout.
    assign timeout = (TIMEOUT_CYCLES > 0) && cyc_g && stb_g &&
                     (wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES)) &&
                     !bus.s_ack_i && !bus.s_err_i;

    always_comb begin
        bus.s_cyc_o  = cyc_g;
        bus.s_stb_o  = cyc_g & stb_g & ~timeout;
        bus.s_we_o   = busy & bus.m_we_i[gnt_idx];
        bus.s_sel_o  = '0;
        bus.s_addr_o = '0;
        bus.s_dat_o  = '0;
        bus.m_ack_o  = '0;
        bus.m_err_o  = '0;
        if (busy) begin
            bus.s_sel_o  = bus.m_sel_i[gnt_idx*SEL_WIDTH +: SEL_WIDTH];
            bus.s_addr_o = bus.m_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            bus.s_dat_o  = bus.m_dat_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        end
        if (cyc_g) begin
            bus.m_err_o[gnt_idx] = bus.s_err_i | timeout;
            bus.m_ack_o[gnt_idx] = bus.s_ack_i & ~bus.s_err_i;
        end
    end

    assign bus.m_dat_o = bus.s_dat_i;
    assign grant_o     = grant;
    assign state_o     = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            wd_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (|bus.m_cyc_i) begin
                        grant  <= pick;
                        state  <= BUSY;
                        rr_ptr <= (win_idx == PTR_WIDTH'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
                BUSY: begin
                    if (!cyc_g) begin
                        state  <= IDLE;
                        grant  <= '0;
                        wd_cnt <= '0;
                    end else if (bus.s_ack_i || bus.s_err_i || timeout) begin
                        wd_cnt <= '0;
                    end else if (bus.s_stb_o && (TIMEOUT_CYCLES > 0)) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Parametrised N-to-1 Wishbone (classic, single-beat) arbiter. It merges several core-side masters onto one slave-side bus, e.g. the instruction and data ports of one or more cores.
- Adds what the core's dedicated per-port buses lack: shared-bus arbitration, fixed or round-robin priority, bus-lock while a master holds cyc, and a watchdog that terminates unanswered cycles with an error.
- Sits between core instances and the system interconnect.

Parameters:
- NUM_MASTERS, 2, number of master channels (1..8); channel 0 is highest priority in FIXED mode.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; multiple of 8.
- PRIORITY_MODE, "FIXED", "FIXED" or "RR" (round-robin).
- TIMEOUT_CYCLES, 255, bus watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- m_cyc_i  in  NUM_MASTERS  per-master cyc.
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  byte selects; channel k occupies slice k.
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  addresses; channel k occupies slice k.
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  write data; channel k occupies slice k.
- m_ack_o  out  NUM_MASTERS  ack, routed to the granted master only.
- m_err_o  out  NUM_MASTERS  err, routed to the granted master only (slave err or timeout).
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters (s_dat_i pass-through).
- s_cyc_o  out  1  slave cyc.
- s_stb_o  out  1  slave stb.
- s_we_o  out  1  slave we.
- s_sel_o  out  DATA_WIDTH/8  slave sel.
- s_addr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- s_dat_i  in  DATA_WIDTH  slave read data.
- grant_o  out  NUM_MASTERS  one-hot current grant; all zero in IDLE.

Behaviour:
- Reset (asynchronous): state IDLE, grant_o=0, RR pointer=0, watchdog counter=0.
  - All s_* outputs are 0; m_ack_o and m_err_o are 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - Slave outputs are 0. Arbitrate over m_cyc_i.
  - FIXED mode: the lowest-index requester wins.
  - RR mode: the first requester at or after the pointer, cyclically, wins.
  - On a win: register grant_o, go to BUSY next edge. RR pointer becomes (winner+1) mod NUM_MASTERS.
  - Arbitration latency is 1 cycle: a master's cyc must be high for one IDLE cycle before its signals appear on the slave bus.
- BUSY:
  - s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_dat_o combinationally mirror the granted channel.
  - s_ack_i and s_err_i pass combinationally to the granted bit of m_ack_o / m_err_o. Other bits stay 0.
  - Grant is held for as long as the granted m_cyc_i is high, so multiple stb/ack beats can occur under one cyc (bus lock).
  - When the granted m_cyc_i falls, s_cyc_o falls the same cycle and the FSM returns to IDLE next edge. This gives one dead cycle between tenures.
  - Other requesters wait; they receive no ack/err.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments every BUSY cycle with s_stb_o=1 and s_ack_i=s_err_i=0. It clears on ack, err, or leaving BUSY.
  - When the counter equals TIMEOUT_CYCLES, the granted m_err_o is asserted for that cycle and the counter clears. s_stb_o is forced 0 in that cycle.
  - Counter width is clog2(TIMEOUT_CYCLES+1) and it never wraps.
- Simultaneous events:
  - s_ack_i and s_err_i both high: only err is forwarded.
  - Slave ack coinciding with a timeout: ack wins and no err is raised.
  - Granted master drops cyc while stb is pending: the transfer is aborted and any late ack/err in IDLE is ignored.
- NUM_MASTERS=1: grant is always channel 0; the 1-cycle arbitration latency still applies.
- Reset asserted mid-transfer: outputs go to 0 immediately (asynchronously); no ack or err is delivered.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, BUSY=1);
  - PRIORITY_MODE string constants;
  - the clog2 function.
- One sub-module, wb_arb_picker: a purely combinational priority/round-robin selector. It takes a request vector and pointer, and returns a one-hot grant.
- Muxing, FSM and watchdog stay in wb_master_arbiter.

Test Plan:
- FIXED, N=2: m_cyc_i=2'b11 from the same edge -> grant_o=2'b01 after 1 cycle. Channel 1 is granted only after ch0 drops cyc, with 1 dead cycle.
- RR, N=3: all three hold requests with single-beat tenures -> grant sequence 001, 010, 100, 001.
- Lock: ch0 performs 3 stb/ack beats under one cyc while ch1 requests -> grant_o stays 01 throughout; ch1 sees no ack.
- Routing: ch1 granted, slave returns s_dat_i=32'hDEADBEEF with ack -> m_ack_o=2'b10, m_dat_o=32'hDEADBEEF.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> m_err_o[granted] pulses exactly 1 cycle, 4 cycles after stb; s_stb_o=0 in that cycle. Ack and err both high -> err only.
- Async reset: assert rst_i mid-BUSY between clock edges -> all outputs 0 before the next edge; after release, first request takes the 1-cycle grant path.
